frogger_game_state: RTL and testbench

- Game-flow controller sitting between the collision/frog-movement stages and the score display and obstacle speed stage.
- Consumes the collision flag, the frog-reached-goal event, the start switch and the VGA frame tick.
- Owns lives, score, level and car speed.
- Produces the play-enable, frog-respawn and game-over controls that gate frog and car movement.

---
 rtl/frogger_game_state_if.sv | 27 ++
 rtl/frogger_game_state.sv | 148 ++++++++++++++
 tb/tb_frogger_game_state.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/frogger_game_state_if.sv
// Game-flow control bundle: event inputs from the collision/frog stages and
// the play/score/speed outputs toward frog, car and display stages.
interface frogger_game_state_if;
    logic       i_Start;
    logic       i_Frame_Tick;
    logic       i_Has_Collided;
    logic       i_Frog_At_Goal;
    logic       o_Play_Enable;
    logic       o_Frog_Respawn;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic [3:0] o_Level;
    logic [3:0] o_Car_Speed;
    logic       o_Game_Over;

    modport slave (
        input  i_Start, i_Frame_Tick, i_Has_Collided, i_Frog_At_Goal,
        output o_Play_Enable, o_Frog_Respawn, o_Lives, o_Score, o_Level,
               o_Car_Speed, o_Game_Over
    );

    modport master (
        output i_Start, i_Frame_Tick, i_Has_Collided, i_Frog_At_Goal,
        input  o_Play_Enable, o_Frog_Respawn, o_Lives, o_Score, o_Level,
               o_Car_Speed, o_Game_Over
    );
endinterface

// File: rtl/frogger_game_state.sv
// Frogger game-flow controller: owns lives, score, level and car speed and
// gates frog/car movement through IDLE/PLAY/HIT/LEVEL_UP/GAME_OVER.
module frogger_game_state #(
    parameter int c_LIVES_INI       = 3,
    parameter int c_GOALS_PER_LEVEL = 3,
    parameter int c_MAX_LEVEL       = 9,
    parameter int c_BASE_CAR_SPEED  = 1,
    parameter int c_HIT_FRAMES      = 60,
    parameter int c_LEVEL_FRAMES    = 30,
    parameter int c_SCORE_MAX       = 99
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    frogger_game_state_if.slave        gs
);

    localparam logic [1:0] LIVES_INI  = 2'(c_LIVES_INI);
    localparam logic [3:0] GOALS_LAST = 4'(c_GOALS_PER_LEVEL - 1);
    localparam logic [3:0] MAX_LEVEL  = 4'(c_MAX_LEVEL);
    localparam logic [3:0] BASE_SPEED = 4'(c_BASE_CAR_SPEED);
    localparam logic [6:0] HIT_LAST   = 7'(c_HIT_FRAMES - 1);
    localparam logic [6:0] LVL_LAST   = 7'(c_LEVEL_FRAMES - 1);
    localparam logic [6:0] SCORE_MAX  = 7'(c_SCORE_MAX);

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_HIT, S_LVL, S_OVER} state_t;

    state_t     state_q, state_d;
    logic [2:0] smp_q, dly_q;            // bit0 start, bit1 collision, bit2 goal
    logic [1:0] lives_q, lives_d;
    logic [6:0] score_q, score_d;
    logic [3:0] level_q, level_d;
    logic [3:0] goals_q, goals_d;
    logic [3:0] speed_q, speed_d;
    logic [6:0] frame_q, frame_d;
    logic       resp_q, resp_d;
    logic       play_q, play_d;
    logic       over_q, over_d;
    logic [2:0] rise;
    logic [4:0] spd_sum;

    // Edge detect on the registered samples so an input edge reaches the
    // outputs after the sample register plus the state register.
    assign rise    = smp_q & ~dly_q;
    assign spd_sum = {1'b0, BASE_SPEED} + {1'b0, level_q};

    // State and datapath registers; reset drops every in-flight event.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= S_IDLE;
            smp_q   <= '0;
            dly_q   <= '0;
            lives_q <= LIVES_INI;
            score_q <= '0;
            level_q <= '0;
            goals_q <= '0;
            speed_q <= BASE_SPEED;
            frame_q <= '0;
            resp_q  <= 1'b0;
            play_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= {gs.i_Frog_At_Goal, gs.i_Has_Collided, gs.i_Start};
            dly_q   <= smp_q;
            lives_q <= lives_d;
            score_q <= score_d;
            level_q <= level_d;
            goals_q <= goals_d;
            speed_q <= speed_d;
            frame_q <= frame_d;
            resp_q  <= resp_d;
            play_q  <= play_d;
            over_q  <= over_d;
        end
    end

    // Next state plus lives/score/level/counter updates for each event.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        level_d = level_q;
        goals_d = goals_q;
        frame_d = frame_q;
        resp_d  = 1'b0;
        speed_d = spd_sum[4] ? 4'hF : spd_sum[3:0];
        case (state_q)
            S_IDLE, S_OVER: begin
                if (rise[0]) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_INI;
                    score_d = '0;
                    level_d = '0;
                    goals_d = '0;
                    resp_d  = 1'b1;
                end
            end
            S_PLAY: begin
                if (rise[1]) begin
                    // Collision wins over a same-cycle goal.
                    lives_d = lives_q - 2'd1;
                    resp_d  = 1'b1;
                    frame_d = '0;
                    state_d = (lives_q == 2'd1) ? S_OVER : S_HIT;
                end else if (rise[2]) begin
                    resp_d  = 1'b1;
                    score_d = (score_q == SCORE_MAX) ? score_q : score_q + 7'd1;
                    if (goals_q == GOALS_LAST) begin
                        goals_d = '0;
                        level_d = (level_q == MAX_LEVEL) ? level_q : level_q + 4'd1;
                        frame_d = '0;
                        state_d = S_LVL;
                    end else begin
                        goals_d = goals_q + 4'd1;
                    end
                end
            end
            S_HIT: begin
                if (gs.i_Frame_Tick) begin
                    if (frame_q == HIT_LAST) state_d = S_PLAY;
                    else                     frame_d = frame_q + 7'd1;
                end
            end
            S_LVL: begin
                if (gs.i_Frame_Tick) begin
                    if (frame_q == LVL_LAST) state_d = S_PLAY;
                    else                     frame_d = frame_q + 7'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so they register with it.
    always_comb begin
        play_d = (state_d == S_PLAY);
        over_d = (state_d == S_OVER);
    end

    assign gs.o_Play_Enable  = play_q;
    assign gs.o_Frog_Respawn = resp_q;
    assign gs.o_Lives        = lives_q;
    assign gs.o_Score        = score_q;
    assign gs.o_Level        = level_q;
    assign gs.o_Car_Speed    = speed_q;
    assign gs.o_Game_Over    = over_q;

endmodule

// File: tb/tb_frogger_game_state.sv
// Directed bench for the frogger game-flow controller.
module tb_frogger_game_state;
    logic i_Clk;
    logic i_Rst_L;
    int   n_chk;
    int   n_err;
    int   resp_cnt;
    int   r0;

    frogger_game_state_if gs ();

    frogger_game_state dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .gs      (gs)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Count respawn pulses, sampled just after each active edge.
    always begin
        @(posedge i_Clk);
        #1;
        if (gs.o_Frog_Respawn) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            gs.i_Frame_Tick = 1'b1;
            @(negedge i_Clk);
            gs.i_Frame_Tick = 1'b0;
            @(negedge i_Clk);
        end
    endtask

    task automatic pulse_start();
        gs.i_Start = 1'b1;
        @(negedge i_Clk);
        gs.i_Start = 1'b0;
        @(negedge i_Clk);
    endtask

    task automatic pulse_coll();
        gs.i_Has_Collided = 1'b1;
        @(negedge i_Clk);
        gs.i_Has_Collided = 1'b0;
        @(negedge i_Clk);
    endtask

    task automatic pulse_goal();
        gs.i_Frog_At_Goal = 1'b1;
        @(negedge i_Clk);
        gs.i_Frog_At_Goal = 1'b0;
        @(negedge i_Clk);
    endtask

    // One level worth of crossings followed by the level-up pause.
    task automatic level_round();
        for (int i = 0; i < 3; i++) pulse_goal();
        frames(30);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        resp_cnt = 0;
        i_Rst_L = 1'b0;
        gs.i_Start = 1'b0;
        gs.i_Frame_Tick = 1'b0;
        gs.i_Has_Collided = 1'b0;
        gs.i_Frog_At_Goal = 1'b0;
        cyc(3);
        chk("rst_play",  gs.o_Play_Enable, 0);
        chk("rst_resp",  gs.o_Frog_Respawn, 0);
        chk("rst_lives", gs.o_Lives, 3);
        chk("rst_score", gs.o_Score, 0);
        chk("rst_level", gs.o_Level, 0);
        chk("rst_speed", gs.o_Car_Speed, 1);
        chk("rst_over",  gs.o_Game_Over, 0);
        i_Rst_L = 1'b1;
        cyc(2);

        // Start: outputs move two edges after the input rises.
        r0 = resp_cnt;
        gs.i_Start = 1'b1;
        cyc(1);
        chk("start_lat1_play", gs.o_Play_Enable, 0);
        gs.i_Start = 1'b0;
        cyc(1);
        chk("start_play",  gs.o_Play_Enable, 1);
        chk("start_resp",  gs.o_Frog_Respawn, 1);
        chk("start_lives", gs.o_Lives, 3);
        chk("start_speed", gs.o_Car_Speed, 1);
        cyc(1);
        chk("start_resp_1cyc", gs.o_Frog_Respawn, 0);
        chk("start_resp_cnt", resp_cnt - r0, 1);

        // Collision held high for 500 cycles fires once.
        r0 = resp_cnt;
        gs.i_Has_Collided = 1'b1;
        cyc(2);
        chk("hit_lives", gs.o_Lives, 2);
        chk("hit_play",  gs.o_Play_Enable, 0);
        frames(59);
        chk("hit_59_play", gs.o_Play_Enable, 0);
        frames(1);
        chk("hit_60_play", gs.o_Play_Enable, 1);
        cyc(378);
        gs.i_Has_Collided = 1'b0;
        cyc(1);
        chk("hold_lives", gs.o_Lives, 2);
        chk("hold_resp_cnt", resp_cnt - r0, 1);
        chk("hold_play", gs.o_Play_Enable, 1);

        // Two more collisions end the game.
        pulse_coll();
        chk("hit2_lives", gs.o_Lives, 1);
        frames(60);
        chk("hit2_play", gs.o_Play_Enable, 1);
        pulse_coll();
        chk("over_lives", gs.o_Lives, 0);
        chk("over_flag",  gs.o_Game_Over, 1);
        chk("over_play",  gs.o_Play_Enable, 0);
        frames(70);
        chk("over_stays", gs.o_Game_Over, 1);
        pulse_start();
        chk("restart_lives", gs.o_Lives, 3);
        chk("restart_score", gs.o_Score, 0);
        chk("restart_over",  gs.o_Game_Over, 0);
        chk("restart_play",  gs.o_Play_Enable, 1);

        // Three crossings advance one level; speed follows a cycle later.
        pulse_goal();
        pulse_goal();
        chk("goal2_score", gs.o_Score, 2);
        chk("goal2_play",  gs.o_Play_Enable, 1);
        pulse_goal();
        chk("lvl_score", gs.o_Score, 3);
        chk("lvl_level", gs.o_Level, 1);
        chk("lvl_play",  gs.o_Play_Enable, 0);
        chk("lvl_speed_old", gs.o_Car_Speed, 1);
        cyc(1);
        chk("lvl_speed", gs.o_Car_Speed, 2);
        pulse_goal();
        chk("lvl_goal_ignored", gs.o_Score, 3);
        frames(29);
        chk("lvl_29_play", gs.o_Play_Enable, 0);
        frames(1);
        chk("lvl_30_play", gs.o_Play_Enable, 1);

        // 24 more crossings reach level 9, then the next 6 saturate.
        for (int r = 0; r < 8; r++) level_round();
        chk("l9_level", gs.o_Level, 9);
        chk("l9_speed", gs.o_Car_Speed, 10);
        level_round();
        level_round();
        chk("l9sat_level", gs.o_Level, 9);
        chk("l9sat_speed", gs.o_Car_Speed, 10);
        chk("l9sat_score", gs.o_Score, 33);

        // Simultaneous collision and goal: collision wins.
        gs.i_Has_Collided = 1'b1;
        gs.i_Frog_At_Goal = 1'b1;
        cyc(1);
        gs.i_Has_Collided = 1'b0;
        gs.i_Frog_At_Goal = 1'b0;
        cyc(1);
        chk("both_lives", gs.o_Lives, 2);
        chk("both_score", gs.o_Score, 33);
        frames(60);
        chk("both_play", gs.o_Play_Enable, 1);

        // 120 crossings: score saturates at 99.
        for (int r = 0; r < 22; r++) level_round();
        chk("sat_score_99", gs.o_Score, 99);
        for (int r = 0; r < 18; r++) level_round();
        chk("sat_score_hold", gs.o_Score, 99);
        chk("sat_level", gs.o_Level, 9);

        // Asynchronous reset in the middle of a HIT wait.
        pulse_coll();
        chk("prerst_lives", gs.o_Lives, 1);
        frames(5);
        @(posedge i_Clk);
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk("arst_lives", gs.o_Lives, 3);
        chk("arst_score", gs.o_Score, 0);
        chk("arst_level", gs.o_Level, 0);
        chk("arst_speed", gs.o_Car_Speed, 1);
        chk("arst_play",  gs.o_Play_Enable, 0);
        chk("arst_over",  gs.o_Game_Over, 0);
        cyc(2);
        i_Rst_L = 1'b1;
        cyc(1);
        frames(60);
        chk("arst_idle_play", gs.o_Play_Enable, 0);
        pulse_start();
        chk("arst_start_play", gs.o_Play_Enable, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
